// File: rtl/regfile_writeback_queue_if.sv
// Producer-side handshake bundle for regfile_writeback_queue: ALU and memory result channels.
interface regfile_writeback_queue_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order write-back FIFO between the ALU/memory producers and the register file write port.
// Define WB_FORWARD_EN to build the forwarding lookup; otherwise the rs*_fwd outputs are tied to 0.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  regfile_writeback_queue_if.slave wb_if,
  input  logic                    stall_wb_i,
  output logic                    reg_write_o,
  output logic [4:0]              rd_addr_o,
  output logic [XLEN-1:0]         rd_data_o,
  input  logic [4:0]              rs1_addr_i,
  input  logic [4:0]              rs2_addr_i,
  output logic                    rs1_fwd_hit_o,
  output logic                    rs2_fwd_hit_o,
  output logic [XLEN-1:0]         rs1_fwd_data_o,
  output logic [XLEN-1:0]         rs2_fwd_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic [CW-1:0]   free_s;
  logic            mem_ready_s, alu_ready_s;
  logic            mem_enq_s, alu_enq_s, deq_s;
  logic [AW-1:0]   alu_slot_s;

  // Ready generation from current occupancy; a same-cycle drain does not free a slot.
  always_comb begin
    free_s = DEPTH_C - count_q;
    if (rst_i) begin
      mem_ready_s = 1'b0;
      alu_ready_s = 1'b0;
    end else begin
      mem_ready_s = (free_s >= CW'(1));
      alu_ready_s = (free_s >= CW'(2)) || ((free_s == CW'(1)) && !wb_if.mem_valid);
    end
  end

  assign wb_if.mem_ready = mem_ready_s;
  assign wb_if.alu_ready = alu_ready_s;

  // Next-state: enqueue (mem older than alu, x0 discarded), drain, output stage.
  always_comb begin
    mem_enq_s  = wb_if.mem_valid && mem_ready_s && (wb_if.mem_rd != 5'd0);
    alu_enq_s  = wb_if.alu_valid && alu_ready_s && (wb_if.alu_rd != 5'd0);
    deq_s      = (count_q != ZERO_C) && !stall_wb_i;
    alu_slot_s = wr_ptr_q + AW'(mem_enq_s);
    wr_ptr_d   = wr_ptr_q + AW'(mem_enq_s) + AW'(alu_enq_s);
    rd_ptr_d   = rd_ptr_q + AW'(deq_s);
    count_d    = count_q + CW'(mem_enq_s) + CW'(alu_enq_s) - CW'(deq_s);
    if (deq_s) begin
      reg_write_d = 1'b1;
      rd_addr_d   = rd_mem_q[rd_ptr_q];
      rd_data_d   = data_mem_q[rd_ptr_q];
    end else begin
      reg_write_d = 1'b0;
      rd_addr_d   = rd_addr_q;
      rd_data_d   = rd_data_q;
    end
  end

  // Control and output-stage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= ZERO_C;
      reg_write_q <= 1'b0;
      rd_addr_q   <= 5'd0;
      rd_data_q   <= {XLEN{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Entry storage is never reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (mem_enq_s) begin
      rd_mem_q[wr_ptr_q]   <= wb_if.mem_rd;
      data_mem_q[wr_ptr_q] <= wb_if.mem_data;
    end
    if (alu_enq_s) begin
      rd_mem_q[alu_slot_s]   <= wb_if.alu_rd;
      data_mem_q[alu_slot_s] <= wb_if.alu_data;
    end
  end

  assign reg_write_o = reg_write_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign count_o     = count_q;
  assign empty_o     = (count_q == ZERO_C);

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the youngest match wins; the output stage ranks below all entries.
  function automatic logic [XLEN:0] fwd_lookup(input logic [4:0] addr);
    logic [XLEN:0] res;
    logic [AW-1:0] idx;
    res = {(XLEN+1){1'b0}};
    if (addr != 5'd0) begin
      res = (reg_write_q && (rd_addr_q == addr)) ? {1'b1, rd_data_q} : res;
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + AW'(i);
        res = ((CW'(i) < count_q) && (rd_mem_q[idx] == addr)) ? {1'b1, data_mem_q[idx]} : res;
      end
    end else begin
      res = {(XLEN+1){1'b0}};
    end
    return res;
  endfunction

  logic [XLEN:0] rs1_fwd_s, rs2_fwd_s;

  // Forwarding lookup for both decode read ports.
  always_comb begin
    rs1_fwd_s = fwd_lookup(rs1_addr_i);
    rs2_fwd_s = fwd_lookup(rs2_addr_i);
  end

  assign rs1_fwd_hit_o  = rs1_fwd_s[XLEN];
  assign rs1_fwd_data_o = rs1_fwd_s[XLEN-1:0];
  assign rs2_fwd_hit_o  = rs2_fwd_s[XLEN];
  assign rs2_fwd_data_o = rs2_fwd_s[XLEN-1:0];
`else
  logic unused_fwd_s;
  assign unused_fwd_s   = ^{rs1_addr_i, rs2_addr_i};
  assign rs1_fwd_hit_o  = 1'b0;
  assign rs1_fwd_data_o = {XLEN{1'b0}};
  assign rs2_fwd_hit_o  = 1'b0;
  assign rs2_fwd_data_o = {XLEN{1'b0}};
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_wb;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_fwd_hit, rs2_fwd_hit;
  logic [63:0] rs1_fwd_data, rs2_fwd_data;
  logic [2:0]  count;
  logic        empty;

  regfile_writeback_queue_if #(.XLEN(XLEN)) wb_if ();

  regfile_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .wb_if(wb_if), .stall_wb_i(stall_wb),
    .reg_write_o(reg_write), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_fwd_hit_o(rs1_fwd_hit), .rs2_fwd_hit_o(rs2_fwd_hit),
    .rs1_fwd_data_o(rs1_fwd_data), .rs2_fwd_data_o(rs2_fwd_data),
    .count_o(count), .empty_o(empty)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: pending entries (front = oldest) plus the output stage
  ent_t        mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_rd   = 5'd0;
  logic [63:0] m_data = 64'd0;

  task automatic check_val(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [64:0] model_fwd(input logic [4:0] a);
`ifdef WB_FORWARD_EN
    if (a == 5'd0) return 65'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == a) return {1'b1, mq[i].data};
    if (m_we && (m_rd == a)) return {1'b1, m_data};
`endif
    return 65'd0;
  endfunction

  // one clock cycle: drive at negedge, check readies/forwarding, advance model at posedge, check state
  task automatic step(input logic r, input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                      input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic st, input logic [4:0] a1, input logic [4:0] a2);
    int   free;
    logic exp_mr, exp_ar, macc, aacc;
    ent_t e;
    rst = r; stall_wb = st; rs1_addr = a1; rs2_addr = a2;
    wb_if.mem_valid = mv; wb_if.mem_rd = mrd; wb_if.mem_data = md;
    wb_if.alu_valid = av; wb_if.alu_rd = ard; wb_if.alu_data = ad;
    #1;
    free   = DEPTH - mq.size();
    exp_mr = !r && (free >= 1);
    exp_ar = !r && ((free >= 2) || ((free == 1) && !mv));
    check_val("mem_ready", {64'd0, wb_if.mem_ready}, {64'd0, exp_mr});
    check_val("alu_ready", {64'd0, wb_if.alu_ready}, {64'd0, exp_ar});
    if (!r) begin
      check_val("rs1_fwd", {rs1_fwd_hit, rs1_fwd_data}, model_fwd(a1));
      check_val("rs2_fwd", {rs2_fwd_hit, rs2_fwd_data}, model_fwd(a2));
    end
    macc = mv && exp_mr;
    aacc = av && exp_ar;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_we = 1'b0; m_rd = 5'd0; m_data = 64'd0;
    end else begin
      if ((mq.size() != 0) && !st) begin
        e = mq.pop_front();
        m_we = 1'b1; m_rd = e.rd; m_data = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (macc && (mrd != 5'd0)) begin e.rd = mrd; e.data = md; mq.push_back(e); end
      if (aacc && (ard != 5'd0)) begin e.rd = ard; e.data = ad; mq.push_back(e); end
    end
    @(negedge clk);
    check_val("reg_write", {64'd0, reg_write}, {64'd0, m_we});
    check_val("rd_addr", {60'd0, rd_addr}, {60'd0, m_rd});
    check_val("rd_data", {1'b0, rd_data}, {1'b0, m_data});
    check_val("count", {62'd0, count}, 65'(mq.size()));
    check_val("empty", {64'd0, empty}, {64'd0, (mq.size() == 0)});
  endtask

  task automatic idle(input logic st, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, st, 5'd7, 5'd0);
  endtask

  initial begin
    rst = 1'b1; stall_wb = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    wb_if.mem_valid = 1'b0; wb_if.mem_rd = 5'd0; wb_if.mem_data = 64'd0;
    wb_if.alu_valid = 1'b0; wb_if.alu_rd = 5'd0; wb_if.alu_data = 64'd0;
    @(negedge clk);
    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);

    // single write
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd5, 5'd0);
    idle(1'b0, 3);

    // simultaneous producers: mem older than alu
    step(1'b0, 1'b1, 5'd3, 64'hA, 1'b1, 5'd4, 64'hB, 1'b0, 5'd3, 5'd4);
    idle(1'b0, 4);

    // full and priority
    step(1'b0, 1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102, 1'b1, 5'd1, 5'd2);
    step(1'b0, 1'b1, 5'd3, 64'h103, 1'b1, 5'd4, 64'h104, 1'b1, 5'd3, 5'd4);
    step(1'b0, 1'b1, 5'd5, 64'h105, 1'b1, 5'd6, 64'h106, 1'b1, 5'd5, 5'd6);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd1, 5'd2);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd1, 5'd2);
    step(1'b0, 1'b1, 5'd8, 64'h108, 1'b1, 5'd9, 64'h109, 1'b1, 5'd8, 5'd9);
    idle(1'b0, 6);

    // x0 drop
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 5'd0);
    idle(1'b0, 3);

    // forwarding: youngest wins, output stage visible, cleared after commit
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h11, 1'b1, 5'd7, 5'd0);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h22, 1'b1, 5'd7, 5'd0);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd0);
    idle(1'b0, 4);

    // reset mid-operation
    step(1'b0, 1'b1, 5'd10, 64'h210, 1'b1, 5'd11, 64'h211, 1'b1, 5'd10, 5'd11);
    step(1'b0, 1'b1, 5'd12, 64'h212, 1'b1, 5'd13, 64'h213, 1'b1, 5'd12, 5'd13);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd11, 5'd13);
    step(1'b1, 1'b1, 5'd14, 64'h214, 1'b1, 5'd15, 64'h215, 1'b0, 5'd11, 5'd13);
    idle(1'b0, 4);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(1'b0, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
